// File: rtl/fetch_queue_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of {pc, instr} pairs with flush, simultaneous push/pop and
// a registered head so decode never sees a combinational path from memory.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  input  logic             pop,
  input  logic             flush,
  output logic [31:0]      head_pc,
  output logic [31:0]      head_instr,
  output logic [CNT_W-1:0] count
);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      head_pc_reg, head_pc_next;
  logic [31:0]      head_instr_reg, head_instr_next;
  logic             pop_eff;

  assign pop_eff = pop && (count_reg != '0);

  always_comb begin
    rd_ptr_next     = rd_ptr_reg + PTR_W'(pop_eff);
    wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
    count_next      = count_reg + CNT_W'(push) - CNT_W'(pop_eff);
    head_pc_next    = 32'h0;
    head_instr_next = INSTR_NOP;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (push && (count_reg == CNT_W'(pop_eff))) begin
      // No older entry survives this cycle, so the incoming word becomes head.
      head_pc_next    = push_pc;
      head_instr_next = push_instr;
    end else if (count_next != '0) begin
      head_pc_next    = pc_mem[rd_ptr_next];
      head_instr_next = instr_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_reg]    <= push_pc;
      instr_mem[wr_ptr_reg] <= push_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      head_pc_reg    <= 32'h0;
      head_instr_reg <= INSTR_NOP;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      head_pc_reg    <= head_pc_next;
      head_instr_reg <= head_instr_next;
    end
  end

  assign head_pc    = head_pc_reg;
  assign head_instr = head_instr_reg;
  assign count      = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and
// queues returned words for decode; redirects flush and restart fetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fq_state_e        state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      target_pc, pc_base;
  logic             push, pop_eff;
  logic [CNT_W-1:0] count_after;

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign push      = (state_reg == FQ_WAIT) && imem_ack && !redirect;
  assign pop_eff   = id_valid && id_ready && !redirect;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    count_after   = redirect ? '0 : q_count + CNT_W'(push) - CNT_W'(pop_eff);
    pc_base       = redirect ? target_pc : (push ? fetch_pc_reg + 32'd4 : fetch_pc_reg);
    case (state_reg)
      FQ_IDLE: begin
        if (redirect) begin
          fetch_pc_next = target_pc;
        end else if (!halt && (q_count < FULL)) begin
          state_next = FQ_WAIT;
          addr_next  = fetch_pc_reg;
        end
      end
      FQ_WAIT, FQ_DROP: begin
        if (imem_ack) begin
          // Occupancy after this cycle decides reissue, so a push can never overflow.
          fetch_pc_next = pc_base;
          if (!halt && (count_after < FULL)) begin
            state_next = FQ_WAIT;
            addr_next  = pc_base;
          end else begin
            state_next = FQ_IDLE;
          end
        end else if (redirect) begin
          fetch_pc_next = target_pc;
          state_next    = FQ_DROP;
        end
      end
      default: state_next = FQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FQ_IDLE;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (fetch_pc_reg),
    .push_instr (imem_rdata),
    .pop        (pop_eff),
    .flush      (redirect),
    .head_pc    (id_pc),
    .head_instr (id_instr),
    .count      (q_count)
  );

  assign imem_req  = (state_reg != FQ_IDLE);
  assign imem_addr = addr_reg;
  assign id_valid  = (q_count != '0);

endmodule
